c_admit: RTL

C_ADMIT -- requirements
Module: c_admit

---
 rtl/c_pkg.sv | 22 ++
 rtl/c_skid.sv | 81 ++++++++
 rtl/c_admit.sv | 104 ++++++++++
 3 files changed

// File: rtl/c_pkg.sv
// Shared types for the unary admission block: skid-buffer state and the buffered entry.
`default_nettype none

package c_pkg;

  // Wide enough for any vector up to 2^16-1 bits; c_admit uses only the low bits.
  localparam int C_VAL_MAX_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [C_VAL_MAX_W-1:0] value;
    logic                   cmpl;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/c_skid.sv
// Two-entry skid buffer with a registered ready; head register drives the output.
`default_nettype none

module c_skid
  import c_pkg::*;
#(
  parameter type T = entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     data_i,
  output logic rdy_o,
  output logic vld_o,
  input  logic pop_i,
  output T     data_o
);

  buf_state_e state_q, state_d;
  T           head_q, head_d;
  T           tail_q, tail_d;
  logic       rdy_q, rdy_d;
  logic       push, pop;

  assign vld_o  = (state_q != ST_EMPTY);
  assign rdy_o  = rdy_q;
  assign data_o = head_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    push    = push_i & rdy_q;
    pop     = vld_o & pop_i;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          head_d  = data_i;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({push, pop})
          2'b10: begin
            tail_d  = data_i;
            state_d = ST_FULL;
          end
          2'b01:   state_d = ST_EMPTY;
          2'b11:   head_d  = data_i;
          default: state_d = ST_ONE;
        endcase
      end
      ST_FULL: begin
        // Ready is low here, so only a pop can occur.
        if (pop) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    rdy_d = (state_d != ST_FULL);
  end

endmodule

`default_nettype wire

// File: rtl/c_admit.sv
// Admits unary / complemented-unary vectors, decodes their value, buffers them and
// keeps saturating admit/reject statistics.
`default_nettype none

module c_admit
  import c_pkg::*;
#(
  parameter int P_W                   = 16,
  parameter int P_ADMIT_COMPLIMENT_EN = 1,
  parameter int P_CNT_W               = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_vld,
  output logic                       o_rdy,
  input  logic [P_W-1:0]             i_x,
  input  logic                       i_is_unary,
  input  logic                       i_is_unary_n,
  output logic                       o_vld,
  input  logic                       i_rdy,
  output logic [$clog2(P_W+1)-1:0]   o_value,
  output logic                       o_cmpl,
  input  logic                       i_clr_stats,
  output logic [P_CNT_W-1:0]         o_admit_cnt,
  output logic [P_CNT_W-1:0]         o_reject_cnt
);

  localparam int VAL_W = $clog2(P_W + 1);

  logic [VAL_W-1:0]   ones;
  logic [VAL_W-1:0]   dec_val;
  logic               accept, take_unary, take_cmpl, admit, reject;
  logic               skid_rdy;
  entry_t             entry_in, entry_out;
  logic [P_CNT_W-1:0] admit_cnt_q, admit_cnt_d;
  logic [P_CNT_W-1:0] reject_cnt_q, reject_cnt_d;
  logic               unused_val_hi;

  always_comb begin
    ones = '0;
    for (int k = 0; k < P_W; k++) begin
      ones = ones + VAL_W'(i_x[k]);
    end
  end

  // Unary wins when both decisions fire (all-zeros / all-ones vectors).
  assign take_unary = i_is_unary;
  assign take_cmpl  = ~i_is_unary & i_is_unary_n & (P_ADMIT_COMPLIMENT_EN != 0);
  assign accept     = i_vld & skid_rdy;
  assign admit      = accept & (take_unary | take_cmpl);
  assign reject     = accept & ~(take_unary | take_cmpl);

  assign dec_val        = take_cmpl ? (VAL_W'(P_W) - ones) : ones;
  assign entry_in.value = C_VAL_MAX_W'(dec_val);
  assign entry_in.cmpl  = take_cmpl;

  c_skid #(
    .T (entry_t)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .push_i (admit),
    .data_i (entry_in),
    .rdy_o  (skid_rdy),
    .vld_o  (o_vld),
    .pop_i  (i_rdy),
    .data_o (entry_out)
  );

  assign o_rdy         = skid_rdy;
  assign o_value       = entry_out.value[VAL_W-1:0];
  assign o_cmpl        = entry_out.cmpl;
  assign unused_val_hi = ^entry_out.value;

  always_comb begin
    admit_cnt_d  = admit_cnt_q;
    reject_cnt_d = reject_cnt_q;
    if (i_clr_stats) begin
      admit_cnt_d  = '0;
      reject_cnt_d = '0;
    end else begin
      if (admit && (admit_cnt_q != '1))
        admit_cnt_d = admit_cnt_q + 1'b1;
      if (reject && (reject_cnt_q != '1))
        reject_cnt_d = reject_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      admit_cnt_q  <= '0;
      reject_cnt_q <= '0;
    end else begin
      admit_cnt_q  <= admit_cnt_d;
      reject_cnt_q <= reject_cnt_d;
    end
  end

  assign o_admit_cnt  = admit_cnt_q;
  assign o_reject_cnt = reject_cnt_q;

endmodule

`default_nettype wire
